// File: rtl/shifter_pkg.sv
// Shared types and constants for the CGIA pixel shifter.
// Holds the shift mode enum, bits-per-pixel constants and width defaults.
package shifter_pkg;

  localparam int DAT_W_DEF   = 16;
  localparam int COLOR_W_DEF = 8;

  localparam logic [3:0] BPP_1 = 4'd1;
  localparam logic [3:0] BPP_2 = 4'd2;
  localparam logic [3:0] BPP_4 = 4'd4;
  localparam logic [3:0] BPP_8 = 4'd8;

  typedef enum logic [2:0] {
    MODE_IDLE,
    MODE_1BPP,
    MODE_2BPP,
    MODE_4BPP,
    MODE_8BPP
  } mode_t;

  function automatic logic [3:0] bpp_of(mode_t m);
    logic [3:0] b;
    b = 4'd0;
    unique case (m)
      MODE_1BPP: b = BPP_1;
      MODE_2BPP: b = BPP_2;
      MODE_4BPP: b = BPP_4;
      MODE_8BPP: b = BPP_8;
      default:   b = 4'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/shifter_mode_dec.sv
// Priority encoder: shift flags -> mode and shift amount (8 > 4 > 2 > 1).
// Ports: shift1_i..shift8_i flags in; mode_o enum and shamt_o (0 = idle) out.
module shifter_mode_dec
  import shifter_pkg::*;
(
  input  logic       shift1_i,
  input  logic       shift2_i,
  input  logic       shift4_i,
  input  logic       shift8_i,
  output mode_t      mode_o,
  output logic [3:0] shamt_o
);

  // Several flags may be high at once, so this is a priority chain.
  always_comb begin
    mode_o = MODE_IDLE;
    case (1'b1)
      shift8_i: mode_o = MODE_8BPP;
      shift4_i: mode_o = MODE_4BPP;
      shift2_i: mode_o = MODE_2BPP;
      shift1_i: mode_o = MODE_1BPP;
      default:  mode_o = MODE_IDLE;
    endcase
  end

  assign shamt_o = bpp_of(mode_o);

endmodule

// File: rtl/shifter.sv
// Pixel shift register: loads a word, shifts it out MSB-first at 1/2/4/8 bpp.
// Ports: dotclk_i, rst_n_i (sync, active-low), dat_i, load_i,
//   shift1_i/shift2_i/shift4_i/shift8_i, color_o; empty_o with SHIFTER_EMPTY_EN.
module shifter
  import shifter_pkg::*;
#(
  parameter int DAT_W   = DAT_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic               dotclk_i,
  input  logic               rst_n_i,
  input  logic [DAT_W-1:0]   dat_i,
  input  logic               load_i,
  input  logic               shift1_i,
  input  logic               shift2_i,
  input  logic               shift4_i,
  input  logic               shift8_i,
`ifdef SHIFTER_EMPTY_EN
  output logic               empty_o,
`endif
  output logic [COLOR_W-1:0] color_o
);

  mode_t            mode;
  logic [3:0]       shamt;
  logic [DAT_W-1:0] sr_q;
  logic [DAT_W-1:0] sr_d;

  shifter_mode_dec u_dec (
    .shift1_i (shift1_i),
    .shift2_i (shift2_i),
    .shift4_i (shift4_i),
    .shift8_i (shift8_i),
    .mode_o   (mode),
    .shamt_o  (shamt)
  );

  // Idle decodes to a zero shift amount, so holding falls out naturally.
  always_comb begin
    sr_d = sr_q << shamt;
    if (load_i) sr_d = dat_i;
  end

  always_ff @(posedge dotclk_i) begin
    if (!rst_n_i) sr_q <= '0;
    else          sr_q <= sr_d;
  end

  always_comb begin
    color_o = '0;
    unique case (mode)
      MODE_1BPP: color_o = COLOR_W'(sr_q[DAT_W-1 -: 1]);
      MODE_2BPP: color_o = COLOR_W'(sr_q[DAT_W-1 -: 2]);
      MODE_4BPP: color_o = COLOR_W'(sr_q[DAT_W-1 -: 4]);
      MODE_8BPP: color_o = COLOR_W'(sr_q[DAT_W-1 -: 8]);
      default:   color_o = '0;
    endcase
  end

`ifdef SHIFTER_EMPTY_EN
  localparam int CNT_W = $clog2(DAT_W + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] step;

  assign step = CNT_W'(shamt);

  // Remaining bits saturate at zero once the word is drained.
  always_comb begin
    cnt_d = (cnt_q > step) ? cnt_q - step : '0;
    if (load_i) cnt_d = CNT_W'(DAT_W);
  end

  always_ff @(posedge dotclk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign empty_o = (cnt_q == '0);
`endif

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: directed literals plus random stimulus
// against an arithmetic model of the pixel register.
module tb_shifter;

  logic       clk;
  logic       rst_n;
  logic [15:0] dat;
  logic       load;
  logic       s1, s2, s4, s8;
  logic [7:0] color;
`ifdef SHIFTER_EMPTY_EN
  logic       empty;
`endif

  int n_chk;
  int n_fail;
  bit active;

  // model state: register value and remaining bit count
  int m_reg;
  int m_rem;

  shifter dut (
    .dotclk_i (clk),
    .rst_n_i  (rst_n),
    .dat_i    (dat),
    .load_i   (load),
    .shift1_i (s1),
    .shift2_i (s2),
    .shift4_i (s4),
    .shift8_i (s8),
`ifdef SHIFTER_EMPTY_EN
    .empty_o  (empty),
`endif
    .color_o  (color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sel_bpp();
    if (s8) return 8;
    if (s4) return 4;
    if (s2) return 2;
    if (s1) return 1;
    return 0;
  endfunction

  function automatic int exp_color();
    int b;
    b = sel_bpp();
    if (b == 0) return 0;
    return m_reg / (1 << (16 - b));
  endfunction

  task automatic tick();
    int b;
    @(posedge clk);
    b = sel_bpp();
    if (!rst_n) begin
      m_reg = 0;
      m_rem = 0;
    end else if (load) begin
      m_reg = int'(dat);
      m_rem = 16;
    end else begin
      m_reg = (m_reg * (1 << b)) % 65536;
      m_rem = (m_rem > b) ? m_rem - b : 0;
    end
    #1;
  endtask

  task automatic flags(input bit f1, f2, f4, f8);
    s1 = f1; s2 = f2; s4 = f4; s8 = f8;
  endtask

  task automatic lit(input string nm, input int e);
    @(negedge clk);
    n_chk++;
    if (int'(color) != e) begin
      n_fail++;
      $display("FAIL %s: color_o=0x%02h expected 0x%02h", nm, color, e);
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      n_chk++;
      if (int'(color) != exp_color()) begin
        n_fail++;
        $display("FAIL model_color: got 0x%02h expected 0x%02h",
                 color, exp_color());
      end
`ifdef SHIFTER_EMPTY_EN
      n_chk++;
      if (empty != (m_rem == 0)) begin
        n_fail++;
        $display("FAIL model_empty: got %0b expected %0b",
                 empty, m_rem == 0);
      end
`endif
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; active = 0;
    m_reg = 0; m_rem = 0;
    rst_n = 1'b0; load = 1'b1; dat = 16'hFFFF;
    flags(1, 1, 1, 1);
    tick();
    active = 1;
    lit("reset", 0);
`ifdef SHIFTER_EMPTY_EN
    n_chk++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_empty: empty_o=%0b expected 1", empty);
    end
`endif
    rst_n = 1'b1;

    load = 1; dat = 16'hAAAA; flags(1, 0, 0, 0); tick();
    load = 0;
    lit("load_1bpp", 8'h01);
    tick();
    lit("shift1", 8'h00);
    flags(0, 1, 0, 0); tick();
    lit("shift2", 8'h01);
    flags(0, 0, 1, 0); tick();
    lit("shift4", 8'h05);

    load = 1; dat = 16'h1234; flags(0, 0, 0, 0); tick();
    load = 0;
    lit("load_idle", 8'h00);
    flags(0, 0, 0, 1); tick();
    lit("shift8_a", 8'h34);
    tick();
    lit("shift8_b", 8'h00);
    tick();
    lit("shift8_sat", 8'h00);

    load = 1; dat = 16'hABCD; tick();
    load = 0;
    lit("load_over_shift8", 8'hAB);

    load = 1; dat = 16'h1234; flags(0, 0, 0, 0); tick();
    load = 0; flags(1, 0, 1, 0);
    lit("prio_view", 8'h01);
    tick();
    lit("prio_shift4", 8'h02);

    load = 1; dat = 16'hFFFF; flags(1, 0, 0, 0); tick();
    load = 0;
    for (int i = 0; i < 15; i++) tick();
    lit("drain_15", 8'h01);
    tick();
    lit("drain_16", 8'h00);

    load = 1; dat = 16'hF00F; tick();
    load = 0; rst_n = 0; tick();
    rst_n = 1;
    lit("mid_reset", 8'h00);

    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      load  = ($urandom_range(0, 5) == 0);
      dat   = 16'($urandom);
      flags($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      tick();
    end

    @(negedge clk);
    active = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
